pixel_scan_ctrl: RTL

- Raster-scan front end that drives the image ROM read port and delivers pixels to image_cache and downstream morphology stages.
- Replaces the free-running address counter with a proper controller:
  - start/busy/done frame control
  - x/y coordinate tracking
  - sof/eol/eof sideband flags
  - valid/ready backpressure on the pixel stream, with ROM read latency absorbed internally.

---
 rtl/pixel_scan_ctrl_pkg.sv | 43 ++++
 rtl/pixel_scan_ctrl_fifo.sv | 66 ++++++
 rtl/pixel_scan_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pixel_scan_ctrl_pkg.sv
// Shared definitions for the raster-scan controller: controller states,
// coordinate width and the sideband record that travels with every pixel.
package pixel_scan_ctrl_pkg;

    localparam int COORD_W = 16;

    // Controller states, kept as plain constants for older tooling.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Sideband part of a pixel beat. The pixel value itself has a
    // parameterised width, so it is concatenated on top of this record
    // ({data, meta}) where the beat is built.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               sof;
        logic               eol;
        logic               eof;
    } pix_meta_t;

    localparam int META_W = $bits(pix_meta_t);

    // Builds the sideband record for coordinate (x, y) of a frame whose
    // last column / last row indices are x_last / y_last.
    function automatic pix_meta_t make_meta(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input logic [COORD_W-1:0] x_last,
        input logic [COORD_W-1:0] y_last
    );
        pix_meta_t m;
        m.x   = x;
        m.y   = y;
        m.sof = (x == '0) && (y == '0);
        m.eol = (x == x_last);
        m.eof = (x == x_last) && (y == y_last);
        return m;
    endfunction

endpackage

// File: rtl/pixel_scan_ctrl_fifo.sv
// Two-entry fall-through valid/ready FIFO. When empty, an incoming beat is
// presented on the read side in the same cycle, so a read issued to a
// 1-cycle ROM reaches the consumer one cycle after the request.
module pix_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_valid,
    input  logic [W-1:0] wr_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [W-1:0] rd_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem_reg [2];
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [1:0]   count_reg;

    logic stored;
    logic pop;
    logic wr_en;
    logic rd_en;

    // Read side: stored head first, otherwise the beat arriving this cycle.
    always_comb begin
        stored   = (count_reg != 2'd0);
        rd_valid = stored | wr_valid;
        rd_data  = '0;
        if (stored) begin
            rd_data = mem_reg[rd_ptr_reg];
        end else if (wr_valid) begin
            rd_data = wr_data;
        end
        pop   = rd_valid & rd_ready;
        // A beat that passes straight through an empty FIFO is never stored.
        wr_en = wr_valid & ~(~stored & rd_ready);
        rd_en = pop & stored;
    end

    // Storage, pointers and occupancy; write+read together keeps the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem_reg[wr_ptr_reg] <= wr_data;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (rd_en) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, wr_en} - {1'b0, rd_en};
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pixel_scan_ctrl.sv
// Raster-scan controller: walks the image ROM in raster order, tags each
// pixel with coordinates and frame/line flags, and delivers it over a
// valid/ready stream. At most two reads are ever outstanding (stored in the
// FIFO or still in the ROM pipe), so backpressure never drops a pixel.
module pixel_scan_ctrl
    import pixel_scan_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 145,
    parameter int IMG_HEIGHT = 145,
    parameter int BASE_ADDR  = 0,
    parameter int CONTINUOUS = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic [15:0]           pix_x,
    output logic [15:0]           pix_y,
    output logic                  pix_sof,
    output logic                  pix_eol,
    output logic                  pix_eof
);

    localparam logic [COORD_W-1:0]    X_LAST    = COORD_W'(IMG_WIDTH - 1);
    localparam logic [COORD_W-1:0]    Y_LAST    = COORD_W'(IMG_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam int                    PAY_W     = DATA_WIDTH + META_W;

    logic [1:0]            state_reg;
    logic [1:0]            state_next;
    logic [COORD_W-1:0]    ix_reg;
    logic [COORD_W-1:0]    iy_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic                  inflight_reg;
    pix_meta_t             cap_meta_reg;

    logic [1:0]       fifo_count;
    logic [PAY_W-1:0] fifo_wr_data;
    logic [PAY_W-1:0] fifo_rd_data;
    logic             fifo_rd_valid;
    pix_meta_t        out_meta;

    logic can_issue;
    logic last_issue;
    logic eof_taken;

    // Read issue gating: stored beats plus the one in the ROM pipe stay <= 2.
    always_comb begin
        can_issue  = (fifo_count == 2'd0) ||
                     ((fifo_count == 2'd1) && !inflight_reg);
        rom_en     = (state_reg == ST_ISSUE) && can_issue;
        last_issue = rom_en && (ix_reg == X_LAST) && (iy_reg == Y_LAST);
        eof_taken  = fifo_rd_valid && pix_ready && out_meta.eof;
    end

    // Frame sequencing. The eof handshake is the moment the FIFO empties
    // with nothing left in flight, since eof is the final read of the frame.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start)      state_next = ST_ISSUE;
            ST_ISSUE: if (last_issue) state_next = ST_DRAIN;
            ST_DRAIN: if (eof_taken)  state_next = ST_DONE;
            ST_DONE:  state_next = ((CONTINUOUS != 0) || start) ? ST_ISSUE : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Raster issue counters and running ROM address; they wrap back to the
    // frame origin on the last read so the next frame needs no preload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ix_reg   <= '0;
            iy_reg   <= '0;
            addr_reg <= ADDR_BASE;
        end else if (rom_en) begin
            if (ix_reg == X_LAST) begin
                ix_reg <= '0;
                if (iy_reg == Y_LAST) begin
                    iy_reg   <= '0;
                    addr_reg <= ADDR_BASE;
                end else begin
                    iy_reg   <= iy_reg + COORD_W'(1);
                    addr_reg <= addr_reg + ADDR_WIDTH'(1);
                end
            end else begin
                ix_reg   <= ix_reg + COORD_W'(1);
                addr_reg <= addr_reg + ADDR_WIDTH'(1);
            end
        end
    end

    // Sideband captured with each read so it lines up with rom_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_reg <= 1'b0;
            cap_meta_reg <= '0;
        end else begin
            inflight_reg <= rom_en;
            if (rom_en) begin
                cap_meta_reg <= make_meta(ix_reg, iy_reg, X_LAST, Y_LAST);
            end
        end
    end

    assign fifo_wr_data = {rom_data, cap_meta_reg};

    pix_skid_fifo #(
        .W (PAY_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (inflight_reg),
        .wr_data  (fifo_wr_data),
        .rd_valid (fifo_rd_valid),
        .rd_ready (pix_ready),
        .rd_data  (fifo_rd_data),
        .count    (fifo_count)
    );

    assign out_meta  = fifo_rd_data[META_W-1:0];
    assign pix_valid = fifo_rd_valid;
    assign pix_data  = fifo_rd_data[PAY_W-1 -: DATA_WIDTH];
    assign pix_x     = out_meta.x;
    assign pix_y     = out_meta.y;
    assign pix_sof   = out_meta.sof;
    assign pix_eol   = out_meta.eol;
    assign pix_eof   = out_meta.eof;
    assign rom_addr  = addr_reg;
    assign busy      = (state_reg == ST_ISSUE) || (state_reg == ST_DRAIN);
    assign done      = (state_reg == ST_DONE);

endmodule
